// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame controller: FSM state encoding,
// default frame length, mic sample type and the complex packing for the FFT input.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_IDLE   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam int FRAME_LEN_DEF = 512;

    typedef logic signed [15:0] sample_t;

    // Four real mic samples become four complex words with zero imaginary part.
    function automatic logic [127:0] pack_fft(input logic [63:0] mics);
        logic [127:0] r;
        sample_t      s;
        r = '0;
        for (int m = 0; m < 4; m++) begin
            s               = mics[16*m +: 16];
            r[32*m +: 32]   = {16'b0, s};
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small skid FIFO between the mic sample strobe and the FFT stream.
// Head entry is read straight from storage registers; push and pop may coincide when full.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames 4-mic sample strobes into AXI-Stream FFT beats after sending one config word.
// Optional FFT_FRAME_CTRL_STATS_EN enables the drop and completed-frame counters.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int          FRAME_LEN  = FRAME_LEN_DEF,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] CFG_WORD   = 16'h0000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic [63:0]                  sample_in,
    input  logic                         sample_valid_in,
    output logic [$clog2(FRAME_LEN)-1:0] index_out,
    output logic [127:0]                 fft_tdata_out,
    output logic                         fft_tvalid_out,
    output logic                         fft_tlast_out,
    input  logic                         fft_tready_in,
    output logic [15:0]                  cfg_tdata_out,
    output logic                         cfg_tvalid_out,
    input  logic                         cfg_tready_in,
    output logic                         frame_done_out,
    output logic                         frame_bad_out,
    output logic                         busy_out,
    output logic [15:0]                  drop_count_out,
    output logic [15:0]                  frame_count_out
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam int EW = 64 + IW;

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            cfg_valid_q;
    logic            done_q;
    logic            frame_bad_q;
    logic            bad_q;

    logic            fifo_full, fifo_empty;
    logic [EW-1:0]   head;
    logic            accept, push, pop, drop, last_xfer;

    // Samples are taken while streaming, or as the first sample of a frame from IDLE.
    assign accept    = sample_valid_in &&
                       ((state_q == ST_STREAM) || (state_q == ST_IDLE && enable_in));
    assign pop       = !fifo_empty && fft_tready_in;
    assign push      = accept && (!fifo_full || pop);
    assign drop      = accept && !push;
    assign last_xfer = pop && fft_tlast_out;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (push),
        .din_i   ({sample_in, idx_q}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign index_out      = head[IW-1:0];
    assign fft_tdata_out  = pack_fft(head[EW-1:IW]);
    assign fft_tvalid_out = !fifo_empty;
    assign fft_tlast_out  = !fifo_empty && (head[IW-1:0] == IW'(FRAME_LEN - 1));
    assign cfg_tdata_out  = CFG_WORD;
    assign cfg_tvalid_out = cfg_valid_q;
    assign frame_done_out = done_q;
    assign frame_bad_out  = frame_bad_q;
    assign busy_out       = (state_q != ST_IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_CONFIG;
            idx_q       <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            frame_bad_q <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            done_q <= last_xfer;
            if (last_xfer) begin
                frame_bad_q <= bad_q;
                bad_q       <= 1'b0;
            end else if (drop) begin
                bad_q <= 1'b1;
            end

            // Index wraps naturally: FRAME_LEN is a power of two.
            if (push) begin
                idx_q <= idx_q + IW'(1);
            end

            case (state_q)
                ST_CONFIG: begin
                    if (cfg_valid_q && cfg_tready_in) begin
                        cfg_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cfg_valid_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (push) state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (push && (idx_q == IW'(FRAME_LEN - 1)) && !enable_in) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_xfer) state_q <= ST_IDLE;
                end
                default: state_q <= ST_CONFIG;
            endcase
        end
    end

`ifdef FFT_FRAME_CTRL_STATS_EN
    logic [15:0] drop_cnt_q, frame_cnt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (last_xfer) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign drop_count_out  = drop_cnt_q;
    assign frame_count_out = frame_cnt_q;
`else
    assign drop_count_out  = '0;
    assign frame_count_out = '0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: directed streams push expected beats,
// a negedge monitor pops and compares every FFT transfer.
module tb_fft_frame_ctrl;

`ifdef FFT_FRAME_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         enable_in;
    logic [63:0]  sample_in;
    logic         sample_valid_in;
    logic [8:0]   index_out;
    logic [127:0] fft_tdata_out;
    logic         fft_tvalid_out, fft_tlast_out, fft_tready_in;
    logic [15:0]  cfg_tdata_out;
    logic         cfg_tvalid_out, cfg_tready_in;
    logic         frame_done_out, frame_bad_out, busy_out;
    logic [15:0]  drop_count_out, frame_count_out;

    fft_frame_ctrl #(
        .FRAME_LEN  (512),
        .FIFO_DEPTH (4),
        .CFG_WORD   (16'h0000)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .index_out       (index_out),
        .fft_tdata_out   (fft_tdata_out),
        .fft_tvalid_out  (fft_tvalid_out),
        .fft_tlast_out   (fft_tlast_out),
        .fft_tready_in   (fft_tready_in),
        .cfg_tdata_out   (cfg_tdata_out),
        .cfg_tvalid_out  (cfg_tvalid_out),
        .cfg_tready_in   (cfg_tready_in),
        .frame_done_out  (frame_done_out),
        .frame_bad_out   (frame_bad_out),
        .busy_out        (busy_out),
        .drop_count_out  (drop_count_out),
        .frame_count_out (frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [63:0] d;
        int          idx;
    } beat_t;

    beat_t        exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           seq = 0;
    int           beats = 0;
    int           tlast_cnt = 0;
    int           done_cnt = 0;
    logic         last_bad = 1'b0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input int s);
        logic [15:0] a;
        a = s[15:0];
        return {~a, a ^ 16'h8000, a + 16'd7, a};
    endfunction

    function automatic logic [127:0] expand(input logic [63:0] d);
        return {16'h0, d[63:48], 16'h0, d[47:32], 16'h0, d[31:16], 16'h0, d[15:0]};
    endfunction

    // Monitor: stability under backpressure, beat contents, frame-done capture.
    always @(negedge clk_in) begin
        beat_t e;
        if (!rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 128'(fft_tvalid_out), 128'(1));
                chk("hold_data", fft_tdata_out, prev_data);
            end
            prev_stall = fft_tvalid_out && !fft_tready_in;
            prev_data  = fft_tdata_out;
            if (fft_tvalid_out && fft_tready_in) begin
                beats++;
                if (fft_tlast_out) tlast_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_unexpected: got index %0d, expected no beat", index_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", fft_tdata_out, expand(e.d));
                    chk("beat_index", 128'(index_out), 128'(e.idx));
                    chk("beat_last", 128'(fft_tlast_out), 128'(e.idx == 511));
                end
            end
            if (frame_done_out) begin
                done_cnt++;
                last_bad = frame_bad_out;
            end
        end
    end

    task automatic drive(input bit v, input int idx, input bit rdy, input bit acc);
        beat_t b;
        @(posedge clk_in); #1;
        sample_valid_in = v;
        fft_tready_in   = rdy;
        if (v) begin
            sample_in = mk(seq);
            if (acc) begin
                b.d   = mk(seq);
                b.idx = idx;
                exp_q.push_back(b);
            end
            seq++;
        end
    endtask

    task automatic wait_drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_in); #2;
            if (exp_q.size() == 0 && !fft_tvalid_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(nm, 128'(exp_q.size()), 128'(0));
        repeat (3) @(negedge clk_in);
        @(posedge clk_in); #2;
    endtask

    initial begin
        int hi, xfer, tv, b0, t0;
        rst_in = 1'b0; enable_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0;
        fft_tready_in = 1'b1; cfg_tready_in = 1'b0;

        // Reset state
        #12;
        chk("rst_cfg_valid", 128'(cfg_tvalid_out), 128'(0));
        chk("rst_fft_valid", 128'(fft_tvalid_out), 128'(0));
        chk("rst_done", 128'(frame_done_out), 128'(0));
        chk("rst_bad", 128'(frame_bad_out), 128'(0));
        chk("rst_drop_cnt", 128'(drop_count_out), 128'(0));
        chk("rst_frame_cnt", 128'(frame_count_out), 128'(0));
        chk("cfg_word", 128'(cfg_tdata_out), 128'(16'h0000));
        rst_in = 1'b1;

        // Config handshake held off for 5 valid cycles; samples during CONFIG ignored
        hi = 0; xfer = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            if (cfg_tvalid_out) begin
                hi++;
                if (cfg_tready_in) xfer++;
            end
            @(posedge clk_in); #1;
            cfg_tready_in   = (hi >= 5);
            enable_in       = 1'b1;
            sample_valid_in = (hi < 3);
        end
        sample_valid_in = 1'b0;
        chk("cfg_valid_cycles", 128'(hi), 128'(6));
        chk("cfg_transfers", 128'(xfer), 128'(1));
        chk("idle_after_cfg", 128'(busy_out), 128'(0));
        chk("cfg_samples_ignored", 128'(fft_tvalid_out), 128'(0));
        chk("cfg_no_drops", 128'(drop_count_out), 128'(0));

        // Frame 1: one sample every 4 cycles, no backpressure
        b0 = beats; t0 = tlast_cnt;
        for (int i = 0; i < 512; i++) begin
            drive(1, i, 1, 1);
            repeat (3) drive(0, 0, 1, 0);
        end
        wait_drain("f1_drain_timeout");
        chk("f1_beats", 128'(beats - b0), 128'(512));
        chk("f1_tlast", 128'(tlast_cnt - t0), 128'(1));
        chk("f1_done", 128'(done_cnt), 128'(1));
        chk("f1_bad", 128'(last_bad), 128'(0));
        chk("f1_frame_cnt", 128'(frame_count_out), 128'(STATS ? 1 : 0));
        chk("f1_streaming", 128'(busy_out), 128'(1));

        // Frame 2: stall fills FIFO, drops, then push+pop on a full FIFO
        for (int i = 0; i < 4; i++) drive(1, i, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        @(posedge clk_in); #2;
        chk("f2_drops_stalled", 128'(drop_count_out), 128'(STATS ? 2 : 0));
        drive(1, 4, 1, 1);
        drive(1, 0, 0, 0);
        @(posedge clk_in); #2;
        chk("f2_full_still", 128'(drop_count_out), 128'(STATS ? 3 : 0));
        for (int i = 5; i < 512; i++) begin
            drive(1, i, 1, 1);
            drive(0, 0, 1, 0);
        end
        wait_drain("f2_drain_timeout");
        chk("f2_done", 128'(done_cnt), 128'(2));
        chk("f2_bad", 128'(last_bad), 128'(1));
        chk("f2_drop_cnt", 128'(drop_count_out), 128'(STATS ? 3 : 0));
        chk("f2_frame_cnt", 128'(frame_count_out), 128'(STATS ? 2 : 0));

        // Frame 3: enable drops at index 300, frame completes then drains to IDLE
        for (int i = 0; i < 512; i++) begin
            drive(1, i, 1, 1);
            if (i == 300) enable_in = 1'b0;
            drive(0, 0, 1, 0);
        end
        chk("f3_busy_drain", 128'(busy_out), 128'(1));
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0);
            drive(0, 0, 1, 0);
        end
        wait_drain("f3_drain_timeout");
        chk("f3_idle", 128'(busy_out), 128'(0));
        chk("f3_done", 128'(done_cnt), 128'(3));
        chk("f3_bad", 128'(last_bad), 128'(0));
        chk("f3_no_drops", 128'(drop_count_out), 128'(STATS ? 3 : 0));

        // Frame 4: reset while index 200 waits in the FIFO
        enable_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive(1, i, 1, 1);
            drive(0, 0, 1, 0);
        end
        drive(1, 200, 0, 1);
        drive(0, 0, 0, 0);
        @(posedge clk_in); #3;
        chk("pre_reset_valid", 128'(fft_tvalid_out), 128'(1));
        rst_in = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_valid", 128'(fft_tvalid_out), 128'(0));
        chk("rst_mid_cfg", 128'(cfg_tvalid_out), 128'(0));
        chk("rst_mid_drop_cnt", 128'(drop_count_out), 128'(0));
        chk("rst_mid_frame_cnt", 128'(frame_count_out), 128'(0));
        repeat (2) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        fft_tready_in = 1'b1;
        cfg_tready_in = 1'b1;
        hi = 0; xfer = 0; tv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            if (cfg_tvalid_out) hi++;
            if (cfg_tvalid_out && cfg_tready_in) xfer++;
            if (fft_tvalid_out) tv++;
        end
        chk("rcfg_transfers", 128'(xfer), 128'(1));
        chk("rcfg_no_data", 128'(tv), 128'(0));
        chk("rcfg_idle", 128'(busy_out), 128'(0));
        for (int i = 0; i < 8; i++) begin
            drive(1, i, 1, 1);
            drive(0, 0, 1, 0);
        end
        wait_drain("f4_drain_timeout");
        chk("f4_frame_cnt", 128'(frame_count_out), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameters: FRAME_LEN, default 512, samples per FFT frame (power of 2); FIFO_DEPTH, default 4, sample skid FIFO entries; CFG_WORD, default 16'h0000, FFT config word.
REQ-002 SHALL have these ports:
- clk_in  input  1  sole clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- enable_in  input  1  1 = stream frames; 0 = finish current frame, then stop.
- sample_in  input  64  four signed 16-bit mic samples, mic0 in [15:0].
- sample_valid_in  input  1  one-cycle strobe; no backpressure.
- index_out  output  $clog2(FRAME_LEN)  in-frame index of head sample, for windowing.
- fft_tdata_out  output  128  {16'b0, mic3, ..., 16'b0, mic0}, imaginary parts zero.
- fft_tvalid_out, fft_tlast_out  output  1 each  AXI-Stream valid/last to FFT.
- fft_tready_in  input  1  FFT ready.
- cfg_tdata_out  output  16  equals CFG_WORD.
- cfg_tvalid_out  output  1  config valid.
- cfg_tready_in  input  1  config ready.
- frame_done_out  output  1  one-cycle pulse after a last beat transfers.
- frame_bad_out  output  1  qualified by frame_done_out; 1 = frame lost samples.
- busy_out  output  1  state != IDLE.
- drop_count_out  output  16  saturating dropped-sample count.
- frame_count_out  output  16  wrapping completed-frame count.

Function
REQ-003 SHALL implement states CONFIG, IDLE, STREAM, DRAIN.
REQ-004 CONFIG: cfg_tvalid_out=1 until cfg_tvalid_out&&cfg_tready_in; then IDLE; samples are ignored, not counted as drops.
REQ-005 IDLE -> STREAM on first sample_valid_in with enable_in=1; that sample is index 0.
REQ-006 STREAM: each valid sample is pushed into the FIFO when not full, tagged with the index counter; the counter increments only on a push.
REQ-007 A sample arriving with the FIFO full SHALL be dropped: drop_count_out+1 (saturating at 16'hFFFF), current frame marked bad; the index counter does not advance.
REQ-008 fft_tvalid_out = FIFO not empty; a transfer is fft_tvalid_out&&fft_tready_in and pops the head; fft_tlast_out=1 iff head index == FRAME_LEN-1.
REQ-009 Minimum latency SHALL be 1 cycle: a sample pushed at edge N is presented from edge N+1.
REQ-010 A push and a pop in the same cycle SHALL both occur on a full FIFO; the incoming sample is not dropped.
REQ-011 The index counter SHALL wrap FRAME_LEN-1 -> 0; the next frame begins immediately with no gap.
REQ-012 After the push of index FRAME_LEN-1 with enable_in=0, the FSM SHALL enter DRAIN: no further pushes; -> IDLE after the last beat transfers.
REQ-013 Last-beat transfer: frame_done_out pulses on the following cycle, frame_bad_out = bad flag, frame_count_out+1, bad flag cleared.
REQ-014 fft_tdata_out and fft_tvalid_out SHALL hold stable while fft_tvalid_out=1 and fft_tready_in=0.

Reset
REQ-015 While rst_in=0, SHALL asynchronously force: state CONFIG, FIFO empty, index 0, counters 0, bad flag 0, all valid/done/bad outputs 0.
REQ-016 Reset mid-frame SHALL discard the partial frame; after release, CONFIG is re-entered and the config word is resent before any data.

Configuration
REQ-017 Macro FFT_FRAME_CTRL_STATS_EN: defined -> drop_count_out and frame_count_out are live per REQ-007/013; undefined -> both tied to 0, counter registers absent, frame_bad_out still functional.

Structure
REQ-018 Shared package fft_pkg SHALL hold the state enum type, FRAME_LEN default, the 16-bit sample typedef, and the 128-bit packing helper.
REQ-019 The FIFO SHALL be a sub-module sample_fifo: registered output, parameter depth, full/empty flags, same-cycle push/pop.

Verification
REQ-020 Reset release, cfg_tready_in=0 for 5 cycles then 1 -> cfg_tvalid_out high 6 cycles, one config transfer, state IDLE.
REQ-021 512 samples, one per 4 cycles, tready=1 -> 512 beats, tlast only on index 511, frame_done_out once, frame_bad_out=0, frame_count_out=1.
REQ-022 tready=0 with samples every cycle, FIFO_DEPTH=4 -> 4 accepted, 5th and later dropped, drop_count_out counts them, frame_bad_out=1 at frame end.
REQ-023 enable_in dropped at index 300 -> frame completes to 511, DRAIN, IDLE, no pushes after index 511.
REQ-024 rst_in asserted at index 200 -> outputs clear same cycle; after release, config resent and next frame starts at index 0.
REQ-025 Full FIFO with simultaneous push and pop -> no drop, occupancy unchanged, data order preserved.
